program_loader: RTL

Boot-time loader that sits directly upstream of the microcontroller's program memory. It receives a framed byte stream from a host-side byte source (e.g. a UART receiver) over a valid/ready handshake and writes 12-bit instructions sequentially into program memory through the load port. It holds the core in reset until a complete, checksum-verified image is in place, then releases it.

---
 rtl/program_loader_if.sv | 26 ++
 rtl/program_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Byte-stream and program-memory load port bundle for program_loader.
//   in_data/in_valid/in_ready : host byte source handshake (source -> loader)
//   load_enable/load_address/load_instruction : loader -> program memory writes
// master : host/memory side, slave : loader side.
interface program_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  load_enable;
   logic [ADDR_WIDTH-1:0] load_address;
   logic [11:0]           load_instruction;

   modport master (
      output in_data, in_valid,
      input  in_ready,
      input  load_enable, load_address, load_instruction
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready,
      output load_enable, load_address, load_instruction
   );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader. Receives a framed byte stream (COUNT, N x {HI, LO},
// CHECK), writes 12-bit instructions sequentially into program memory, and
// holds the core in reset until a checksum-verified image is in place.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   ld            : byte stream handshake + program memory load port
//   reload        : single-cycle request for a new load (RUN/ERROR only)
//   mcu_rst       : active-high hold-reset to the core
//   done, error   : image loaded and running / load failed
//
// state   | meaning
// S_COUNT | waiting (indefinitely) for the instruction count byte
// S_HI    | waiting for the high byte of an instruction
// S_LO    | waiting for the low byte of an instruction
// S_WRITE | one-cycle memory write slot, no byte accepted
// S_CHECK | waiting for the checksum byte
// S_RUN   | image verified, core released
// S_ERROR | load failed, core held in reset
module program_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int TIMEOUT    = 65535
) (
   input  logic               clk,
   input  logic               rst,
   program_loader_if.slave    ld,
   input  logic               reload,
   output logic               mcu_rst,
   output logic               done,
   output logic               error
);
   typedef enum logic [2:0] {
      S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_RUN, S_ERROR
   } state_t;

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] index_q, index_d;
   logic [ADDR_WIDTH-1:0] last_q, last_d;
   logic [3:0]            hi_q, hi_d;
   logic [7:0]            chk_q, chk_d;
   logic [TW-1:0]         cnt_q, cnt_d;
   logic                  le_q, le_d;
   logic [ADDR_WIDTH-1:0] la_q, la_d;
   logic [11:0]           li_q, li_d;

   logic accept;
   logic count_too_big;
   logic timeout_hit;

   assign accept = ld.in_valid & ld.in_ready;

   // A count larger than the memory depth can only occur for narrow memories.
   if (ADDR_WIDTH < 8) begin : g_narrow
      assign count_too_big = (ld.in_data > 8'(DEPTH));
   end else begin : g_full
      assign count_too_big = 1'b0;
   end

   // Fires on the idle cycle that would bring the count to TIMEOUT.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_COUNT;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_COUNT: if (accept) state_d = count_too_big ? S_ERROR : S_HI;
         S_HI:    if (accept) state_d = S_LO;
                  else if (timeout_hit) state_d = S_ERROR;
         S_LO:    if (accept) state_d = S_WRITE;
                  else if (timeout_hit) state_d = S_ERROR;
         S_WRITE: state_d = (index_q == last_q) ? S_CHECK : S_HI;
         S_CHECK: if (accept) state_d = (ld.in_data == chk_q) ? S_RUN : S_ERROR;
                  else if (timeout_hit) state_d = S_ERROR;
         S_RUN, S_ERROR: if (reload) state_d = S_COUNT;
         default: state_d = S_COUNT;
      endcase
   end

   always_comb begin
      index_d = index_q;
      last_d  = last_q;
      hi_d    = hi_q;
      chk_d   = chk_q;
      cnt_d   = cnt_q;
      le_d    = 1'b0;
      la_d    = la_q;
      li_d    = li_q;
      case (state_q)
         S_COUNT: begin
            index_d = '0;
            cnt_d   = '0;
            if (accept) begin
               chk_d  = ld.in_data;
               // N = 0 yields all-ones, i.e. the last address of a full-depth image.
               last_d = ld.in_data[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
            end
         end
         S_HI: begin
            if (accept) begin
               hi_d  = ld.in_data[3:0];
               chk_d = chk_q ^ ld.in_data;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_LO: begin
            if (accept) begin
               chk_d = chk_q ^ ld.in_data;
               cnt_d = '0;
               le_d  = 1'b1;
               la_d  = index_q;
               li_d  = {hi_q, ld.in_data};
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_WRITE: begin
            if (index_q != last_q) index_d = index_q + ADDR_WIDTH'(1);
         end
         S_CHECK: begin
            if (accept) cnt_d = '0;
            else        cnt_d = cnt_q + TW'(1);
         end
         default: begin
            cnt_d = '0;
            if (reload) begin
               index_d = '0;
               chk_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         index_q <= '0;
         last_q  <= '0;
         hi_q    <= '0;
         chk_q   <= '0;
         cnt_q   <= '0;
         le_q    <= 1'b0;
         la_q    <= '0;
         li_q    <= '0;
      end else begin
         index_q <= index_d;
         last_q  <= last_d;
         hi_q    <= hi_d;
         chk_q   <= chk_d;
         cnt_q   <= cnt_d;
         le_q    <= le_d;
         la_q    <= la_d;
         li_q    <= li_d;
      end
   end

   always_comb begin
      ld.in_ready         = (state_q == S_COUNT) || (state_q == S_HI) ||
                            (state_q == S_LO)    || (state_q == S_CHECK);
      ld.load_enable      = le_q;
      ld.load_address     = la_q;
      ld.load_instruction = li_q;
      mcu_rst             = (state_q != S_RUN);
      done                = (state_q == S_RUN);
      error               = (state_q == S_ERROR);
   end
endmodule
